// File: rtl/ddr_capture_writer.sv
// ddr_capture_writer: packs 16-bit logic-analyzer samples into 64-bit words
// and issues single-beat MIG write commands into a circular capture region.
// Runs entirely in the MIG ui_clk domain.
module ddr_capture_writer #(
  parameter int                ADDR_W      = 27,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                DEPTH_WORDS = 1 << 20,
  parameter int                ADDR_STEP   = 4
) (
  input  logic              ui_clk,
  input  logic              sys_rst,
  input  logic              init_calib_complete,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [63:0]       app_wdf_data,
  output logic [7:0]        app_wdf_mask,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  output logic              busy,
  output logic              done,
  output logic              wrapped,
  output logic              overrun,
  output logic [ADDR_W-1:0] wr_ptr
);

  typedef enum logic [2:0] {IDLE, WAIT_CAL, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'((DEPTH_WORDS - 1) * ADDR_STEP);

  state_t            state;
  logic [63:0]       pack_data;
  logic [2:0]        pack_cnt;     // samples held in the pack, 0..4
  logic              pend_valid;   // a word owns the MIG command/data outputs
  logic              pack_full;
  logic              accept;
  logic              retire;
  logic              load;
  logic [ADDR_W-1:0] ptr_after;
  logic [7:0]        word_mask;

  assign pack_full = (pack_cnt == 3'd4);
  // Only a full pack facing an occupied pending slot can stall the sample stream.
  assign s_ready   = (state == RUN) && !(pack_full && pend_valid);
  assign accept    = s_valid && s_ready;
  // A handshake already completed leaves its enable low, so it counts as satisfied.
  assign retire    = pend_valid && (!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy);
  // A pending slot being retired this cycle can take the next word immediately.
  assign load      = ((state == RUN && pack_full) || (state == DRAIN && pack_cnt != 3'd0))
                     && (!pend_valid || retire);
  assign ptr_after = (wr_ptr == LAST_ADDR) ? BASE_ADDR : wr_ptr + STEP;

  assign app_cmd     = 3'b000;
  assign app_wdf_end = app_wdf_wren;
  assign busy        = (state == WAIT_CAL) || (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);

  // Byte mask for the word being loaded: unfilled 16-bit slots are masked off.
  always_comb begin
    // NOTE: every path assigns word_mask, so no latch is inferred.
    word_mask = 8'h00;
    case (pack_cnt)
      3'd1:    word_mask = 8'hFC;
      3'd2:    word_mask = 8'hF0;
      3'd3:    word_mask = 8'hC0;
      default: word_mask = 8'h00;
    endcase
  end

  // Control FSM plus sticky status and the write pointer.
  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= IDLE;
      wrapped <= 1'b0;
      overrun <= 1'b0;
      wr_ptr  <= BASE_ADDR;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (retire) begin
        wr_ptr <= ptr_after;
        if (wr_ptr == LAST_ADDR) wrapped <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (stop)       state <= DONE;
          else if (start) state <= WAIT_CAL;
        end
        WAIT_CAL: begin
          if (stop)                     state <= DONE;
          else if (init_calib_complete) state <= RUN;
        end
        RUN: begin
          if (s_valid && !s_ready) overrun <= 1'b1;
          if (stop)                state <= DRAIN;
        end
        DRAIN: begin
          if (pack_cnt == 3'd0 && !pend_valid) state <= DONE;
        end
        DONE: begin
          if (start) begin
            state   <= WAIT_CAL;
            wrapped <= 1'b0;
            overrun <= 1'b0;
            wr_ptr  <= BASE_ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sample packer: slot k of the word holds bits [16k+15:16k].
  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pack_data <= '0;
      pack_cnt  <= 3'd0;
    end else if (load) begin
      pack_data <= '0;
      pack_cnt  <= 3'd0;
      if (accept) begin
        pack_data[15:0] <= s_data;
        pack_cnt        <= 3'd1;
      end
    end else if (accept) begin
      pack_data[{pack_cnt[1:0], 4'b0000} +: 16] <= s_data;
      pack_cnt <= pack_cnt + 3'd1;
    end
  end

  // Pending word: command and data enables drop independently on their handshakes.
  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pend_valid   <= 1'b0;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_addr     <= '0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
    end else begin
      if (app_en && app_rdy)           app_en       <= 1'b0;
      if (app_wdf_wren && app_wdf_rdy) app_wdf_wren <= 1'b0;
      if (retire)                      pend_valid   <= 1'b0;
      if (load) begin
        pend_valid   <= 1'b1;
        app_en       <= 1'b1;
        app_wdf_wren <= 1'b1;
        app_addr     <= retire ? ptr_after : wr_ptr;
        app_wdf_data <= pack_data;
        app_wdf_mask <= word_mask;
      end
    end
  end

endmodule

// File: tb/tb_ddr_capture_writer.sv
// Self-checking bench for ddr_capture_writer (DEPTH_WORDS=4 to exercise wrap).
module tb_ddr_capture_writer;

  localparam int AW = 27;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          init_calib_complete;
  logic          start;
  logic          stop;
  logic [15:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [63:0]   app_wdf_data;
  logic [7:0]    app_wdf_mask;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic          busy;
  logic          done;
  logic          wrapped;
  logic          overrun;
  logic [AW-1:0] wr_ptr;

  ddr_capture_writer #(.ADDR_W(AW), .BASE_ADDR('0), .DEPTH_WORDS(4), .ADDR_STEP(4)) dut (
    .ui_clk(clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
    .start(start), .stop(stop), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy), .busy(busy), .done(done),
    .wrapped(wrapped), .overrun(overrun), .wr_ptr(wr_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic [63:0]   care;
    logic [7:0]    mask;
  } wr_vec_t;

  localparam int N_WR = 13;
  wr_vec_t exp_tab [N_WR];

  int n_vec  = 0;
  int n_fail = 0;

  logic [AW-1:0] cmd_q  [$];
  logic [63:0]   dat_q  [$];
  logic [7:0]    msk_q  [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Record every completed MIG handshake in arrival order.
  always @(negedge clk) begin
    if (!sys_rst) begin
      if (app_en && app_rdy) begin
        cmd_q.push_back(app_addr);
        check("app_cmd_write", 64'(app_cmd), 64'd0);
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        dat_q.push_back(app_wdf_data);
        msk_q.push_back(app_wdf_mask);
        check("app_wdf_end", 64'(app_wdf_end), 64'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Raise s_valid only once s_ready is seen, so no overrun is provoked.
  task automatic push(input logic [15:0] d, input logic with_stop = 1'b0);
    int w = 0;
    @(negedge clk);
    while (!s_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) begin
      check("push_timeout", 64'(s_ready), 64'd1);
    end else begin
      s_valid = 1'b1;
      s_data  = d;
      stop    = with_stop;
      tick();
      s_valid = 1'b0;
      stop    = 1'b0;
    end
  endtask

  task automatic push_run(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) push(first + 16'(i));
  endtask

  task automatic wait_writes();
    int w = 0;
    repeat (3) tick();
    while ((app_en || app_wdf_wren) && w < 200) begin
      tick();
      w++;
    end
    check("writes_settle", 64'(app_en || app_wdf_wren), 64'd0);
  endtask

  task automatic wait_done();
    int w = 0;
    while (!done && w < 200) begin
      tick();
      w++;
    end
    check("wait_done", 64'(done), 64'd1);
  endtask

  initial begin
    logic seen;
    int   w;

    exp_tab[0]  = '{27'd0,  64'h0004_0003_0002_0001, {64{1'b1}}, 8'h00};
    exp_tab[1]  = '{27'd4,  64'h0008_0007_0006_0005, {64{1'b1}}, 8'h00};
    exp_tab[2]  = '{27'd8,  64'h0024_0023_0022_0021, {64{1'b1}}, 8'h00};
    exp_tab[3]  = '{27'd12, 64'h0028_0027_0026_0025, {64{1'b1}}, 8'h00};
    exp_tab[4]  = '{27'd0,  64'h002C_002B_002A_0029, {64{1'b1}}, 8'h00};
    exp_tab[5]  = '{27'd4,  64'h0054_0053_0052_0051, {64{1'b1}}, 8'h00};
    exp_tab[6]  = '{27'd8,  64'h0000_0000_0056_0055, 64'h0000_0000_FFFF_FFFF, 8'hF0};
    exp_tab[7]  = '{27'd0,  64'h0034_0033_0032_0031, {64{1'b1}}, 8'h00};
    exp_tab[8]  = '{27'd4,  64'h0038_0037_0036_0035, {64{1'b1}}, 8'h00};
    exp_tab[9]  = '{27'd8,  64'h003C_003B_003A_0039, {64{1'b1}}, 8'h00};
    exp_tab[10] = '{27'd12, 64'h0040_003F_003E_003D, {64{1'b1}}, 8'h00};
    exp_tab[11] = '{27'd0,  64'h0044_0043_0042_0041, {64{1'b1}}, 8'h00};
    exp_tab[12] = '{27'd0,  64'h0074_0073_0072_0071, {64{1'b1}}, 8'h00};

    sys_rst = 1'b1; init_calib_complete = 1'b1; start = 1'b0; stop = 1'b0;
    s_data = '0; s_valid = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();

    // Reset state.
    check("rst_app_en", 64'(app_en), 64'd0);
    check("rst_wren",   64'(app_wdf_wren), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_done",   64'(done), 64'd0);
    check("rst_flags",  64'({wrapped, overrun}), 64'd0);
    check("rst_wr_ptr", 64'(wr_ptr), 64'd0);

    // Basic capture: 8 samples -> two full words.
    pulse_start();
    push_run(16'h0001, 8);
    wait_writes();
    check("t1_wr_ptr", 64'(wr_ptr), 64'd8);
    check("t1_busy",   64'(busy), 64'd1);

    // Skewed backpressure: data ready returns after 3 cycles, command after ~10.
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    push_run(16'h0021, 8);
    tick();
    check("t3_s_ready_low", 64'(s_ready), 64'd0);
    check("t3_en_wren",     64'({app_en, app_wdf_wren}), 64'b11);
    check("t3_addr",        64'(app_addr), 64'd8);
    check("t3_data",        app_wdf_data, 64'h0024_0023_0022_0021);
    repeat (2) tick();
    app_wdf_rdy = 1'b1;
    tick();
    check("t3_wren_dropped", 64'({app_en, app_wdf_wren}), 64'b10);
    check("t3_addr_stable",  64'(app_addr), 64'd8);
    check("t3_data_stable",  app_wdf_data, 64'h0024_0023_0022_0021);
    check("t3_no_overrun",   64'(overrun), 64'd0);
    s_valid = 1'b1; s_data = 16'h0029;
    repeat (5) tick();
    check("t3_overrun", 64'(overrun), 64'd1);
    check("t3_addr_held", 64'(app_addr), 64'd8);
    app_rdy = 1'b1;
    w = 0;
    @(negedge clk);
    while (!s_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("t3_ready_back", 64'(s_ready), 64'd1);
    tick();
    s_valid = 1'b0;
    push_run(16'h002A, 3);
    wait_writes();
    check("t3_wr_ptr",  64'(wr_ptr), 64'd4);
    check("t3_wrapped", 64'(wrapped), 64'd1);

    // Partial flush: 5 samples, then the 6th together with stop.
    push_run(16'h0051, 5);
    push(16'h0056, 1'b1);
    wait_done();
    check("t5_busy",    64'(busy), 64'd0);
    check("t5_wr_ptr",  64'(wr_ptr), 64'd12);
    check("t5_sticky",  64'({wrapped, overrun}), 64'b11);

    // Restart from DONE clears status; 20 samples wrap the 4-word region.
    pulse_start();
    check("t4_cleared", 64'({done, wrapped, overrun}), 64'd0);
    check("t4_wr_ptr0", 64'(wr_ptr), 64'd0);
    push_run(16'h0031, 12);
    wait_writes();
    check("t4_ptr_12",    64'(wr_ptr), 64'd12);
    check("t4_no_wrap_3", 64'(wrapped), 64'd0);
    push_run(16'h003D, 4);
    wait_writes();
    check("t4_ptr_wrap",  64'(wr_ptr), 64'd0);
    check("t4_wrap_4",    64'(wrapped), 64'd1);
    push_run(16'h0041, 4);
    wait_writes();
    check("t4_ptr_final", 64'(wr_ptr), 64'd4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done();

    // Calibration gate: nothing moves until init_calib_complete rises.
    init_calib_complete = 1'b0;
    pulse_start();
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      seen |= s_ready | app_en;
    end
    check("t2_gated", 64'(seen), 64'd0);
    check("t2_busy",  64'(busy), 64'd1);
    init_calib_complete = 1'b1;
    push_run(16'h0071, 4);
    wait_writes();
    check("t2_wr_ptr", 64'(wr_ptr), 64'd4);

    // Async reset while a command is stalled.
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    push_run(16'h0061, 4);
    w = 0;
    while (!app_en && w < 20) begin
      tick();
      w++;
    end
    check("t6_en_before", 64'(app_en), 64'd1);
    #2 sys_rst = 1'b1;
    #1;
    check("t6_en_wren", 64'({app_en, app_wdf_wren}), 64'd0);
    check("t6_wr_ptr",  64'(wr_ptr), 64'd0);
    check("t6_status",  64'({busy, done, s_ready}), 64'd0);
    tick();
    sys_rst = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    repeat (3) tick();
    check("t6_abandoned", 64'(app_en), 64'd0);

    // stop in IDLE goes straight to DONE without writes.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("idle_stop_done", 64'({done, busy}), 64'b10);
    repeat (3) tick();

    // Compare every recorded write against the expected table.
    check("n_cmd", 64'(cmd_q.size()), 64'(N_WR));
    check("n_dat", 64'(dat_q.size()), 64'(N_WR));
    for (int i = 0; i < N_WR; i++) begin
      if (i < cmd_q.size()) check($sformatf("wr%0d_addr", i), 64'(cmd_q[i]), 64'(exp_tab[i].addr));
      if (i < dat_q.size()) begin
        check($sformatf("wr%0d_data", i), dat_q[i] & exp_tab[i].care, exp_tab[i].data & exp_tab[i].care);
        check($sformatf("wr%0d_mask", i), 64'(msk_q[i]), 64'(exp_tab[i].mask));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
